// File: rtl/seven_segment_scanner.sv
`default_nettype none
// ============================================================================
//  Module      : seven_segment_scanner
//  Description : Time-multiplexed N-digit hex 7-segment driver with per-frame
//                input snapshot, decimal points, leading-zero blanking, PWM
//                brightness, selectable output polarity and frame strobe.
//  Revision    : 1.0 - initial release
// ============================================================================
module seven_segment_scanner #(
    parameter int NUM_DIGITS     = 4,
    parameter int REFRESH_DIV    = 50000,
    parameter int BRIGHT_W       = 3,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit AN_ACTIVE_LOW  = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [4*NUM_DIGITS-1:0] number,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic                    blank_lz,
    input  logic [BRIGHT_W-1:0]     brightness,
    input  logic                    enable,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    frame_start
);

    localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    // Wide enough to hold (2**BRIGHT_W) * REFRESH_DIV without truncation.
    localparam int PW = CW + BRIGHT_W + 1;

    localparam logic [CW-1:0] SLOT_LAST = CW'(REFRESH_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_DIGITS - 1);
    localparam logic [PW-1:0] DIV_W     = PW'(REFRESH_DIV);

    logic [CW-1:0]           slot_cnt;
    logic [IW-1:0]           idx;
    logic [4*NUM_DIGITS-1:0] snap_number;
    logic [NUM_DIGITS-1:0]   snap_dp;
    logic                    snap_blank;
    logic                    load_pending;

    logic                    load;
    logic [PW-1:0]           pwm_lhs;
    logic [PW-1:0]           pwm_rhs;
    logic                    anode_on;
    logic [NUM_DIGITS-1:0]   lead_zero;
    logic [3:0]              cur_digit;
    logic                    cur_dp;
    logic                    cur_blank;
    logic [6:0]              seg_on;
    logic [NUM_DIGITS-1:0]   an_on;

    // Active-high gfedcba pattern for one hex nibble.
    function automatic logic [6:0] hex_decode(input logic [3:0] h);
        logic [6:0] s;
        case (h)
            4'h0: s = 7'h3F;
            4'h1: s = 7'h06;
            4'h2: s = 7'h5B;
            4'h3: s = 7'h4F;
            4'h4: s = 7'h66;
            4'h5: s = 7'h6D;
            4'h6: s = 7'h7D;
            4'h7: s = 7'h07;
            4'h8: s = 7'h7F;
            4'h9: s = 7'h6F;
            4'hA: s = 7'h77;
            4'hB: s = 7'h7C;
            4'hC: s = 7'h39;
            4'hD: s = 7'h5E;
            4'hE: s = 7'h79;
            default: s = 7'h71;
        endcase
        return s;
    endfunction

    // Snapshot at the very end of a frame (last cycle of last digit) or right after reset.
    assign load = load_pending || ((slot_cnt == SLOT_LAST) && (idx == IDX_LAST));

    // Slot counter, digit index and the tear-free input snapshot.
    always_ff @(posedge clk) begin
        if (!rst) begin
            slot_cnt     <= '0;
            idx          <= '0;
            snap_number  <= '0;
            snap_dp      <= '0;
            snap_blank   <= 1'b0;
            load_pending <= 1'b1;
        end else begin
            if (slot_cnt == SLOT_LAST) begin
                slot_cnt <= '0;
                idx      <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
            end else begin
                slot_cnt <= slot_cnt + 1'b1;
            end
            if (load) begin
                snap_number  <= number;
                snap_dp      <= dp_in;
                snap_blank   <= blank_lz;
                load_pending <= 1'b0;
            end
        end
    end

    // lead_zero[i] = snapshot digits NUM_DIGITS-1 down to i are all zero.
    always_comb begin
        logic zero_run;
        zero_run  = 1'b1;
        lead_zero = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            zero_run     = zero_run && (snap_number[4*i +: 4] == 4'h0);
            lead_zero[i] = zero_run;
        end
    end

    // Pick the currently scanned digit and decide blanking, PWM gating and patterns.
    always_comb begin
        cur_digit = 4'h0;
        cur_dp    = 1'b0;
        cur_blank = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx == IW'(i)) begin
                cur_digit = snap_number[4*i +: 4];
                cur_dp    = snap_dp[i];
                cur_blank = snap_blank && (i != 0) && lead_zero[i];
            end
        end
        // Duty = (brightness+1)/2**BRIGHT_W of each slot, scaled onto slot_cnt.
        pwm_lhs  = PW'(slot_cnt) << BRIGHT_W;
        pwm_rhs  = (PW'(brightness) + PW'(1)) * DIV_W;
        anode_on = enable && (pwm_lhs < pwm_rhs);
        an_on    = anode_on ? (NUM_DIGITS'(1) << idx) : '0;
        seg_on   = (anode_on && !cur_blank) ? hex_decode(cur_digit) : 7'h00;
    end

    // Registered outputs with polarity applied; a dark anode also darkens seg/dp.
    always_ff @(posedge clk) begin
        if (!rst) begin
            seg         <= {7{SEG_ACTIVE_LOW}};
            dp          <= SEG_ACTIVE_LOW;
            an          <= {NUM_DIGITS{AN_ACTIVE_LOW}};
            frame_start <= 1'b0;
        end else begin
            seg         <= seg_on ^ {7{SEG_ACTIVE_LOW}};
            dp          <= (anode_on && cur_dp) ^ SEG_ACTIVE_LOW;
            an          <= an_on ^ {NUM_DIGITS{AN_ACTIVE_LOW}};
            frame_start <= load;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_seven_segment_scanner.sv
`default_nettype none
// ============================================================================
//  Module      : tb_seven_segment_scanner
//  Description : Scoreboard bench for seven_segment_scanner (4 digits,
//                4 clk slots, 2-bit brightness, active-low outputs).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_seven_segment_scanner;

    localparam int N  = 4;
    localparam int R  = 4;
    localparam int BW = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic [15:0]   number;
    logic [3:0]    dp_in;
    logic          blank_lz;
    logic [1:0]    brightness;
    logic          enable;
    logic [6:0]    seg;
    logic          dp;
    logic [3:0]    an;
    logic          frame_start;

    seven_segment_scanner #(
        .NUM_DIGITS     (N),
        .REFRESH_DIV    (R),
        .BRIGHT_W       (BW),
        .SEG_ACTIVE_LOW (1'b1),
        .AN_ACTIVE_LOW  (1'b1)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .number      (number),
        .dp_in       (dp_in),
        .blank_lz    (blank_lz),
        .brightness  (brightness),
        .enable      (enable),
        .seg         (seg),
        .dp          (dp),
        .an          (an),
        .frame_start (frame_start)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [6:0] seg;
        logic       dp;
        logic [3:0] an;
        logic       fs;
    } exp_t;

    exp_t        q[$];
    int          vectors     = 0;
    int          miscompares = 0;
    bit          fs_seen;

    logic [6:0]  dec [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                              7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    // Reference model state: cycles since reset release plus the frame snapshot.
    int          t;
    logic [15:0] m_num;
    logic [3:0]  m_dp;
    logic        m_blank;
    bit          m_pend;

    // Reference model: predicts what the outputs will show after this edge.
    always @(posedge clk) begin
        exp_t       e;
        int         slot;
        int         dig;
        int         hi;
        bit         on;
        bit         blanked;
        bit         load;
        logic [3:0] h;
        logic [6:0] seg_hi;
        logic [3:0] an_hi;
        logic       dp_hi;
        if (!rst) begin
            e.seg = 7'h7F; e.dp = 1'b1; e.an = 4'hF; e.fs = 1'b0;
            t = 0; m_num = '0; m_dp = '0; m_blank = 1'b0; m_pend = 1'b1;
        end else begin
            slot = t % R;
            dig  = (t / R) % N;
            on   = enable && ((slot * (1 << BW)) < ((int'(brightness) + 1) * R));
            hi   = -1;
            for (int i = 0; i < N; i++)
                if (m_num[4*i +: 4] != 4'h0) hi = i;
            blanked = m_blank && (dig > 0) && (dig > hi);
            h       = m_num[4*dig +: 4];
            seg_hi  = (on && !blanked) ? dec[h] : 7'h00;
            dp_hi   = on && m_dp[dig];
            an_hi   = on ? (4'b0001 << dig) : 4'b0000;
            e.seg   = ~seg_hi;
            e.dp    = ~dp_hi;
            e.an    = ~an_hi;
            load    = m_pend || ((slot == R - 1) && (dig == N - 1));
            e.fs    = load;
            if (load) begin
                m_num = number; m_dp = dp_in; m_blank = blank_lz; m_pend = 1'b0;
            end
            t++;
        end
        q.push_back(e);
    end

    // Monitor: outputs change every cycle, so one expected entry is consumed per cycle.
    always @(negedge clk) begin
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            vectors++;
            if ({seg, dp, an, frame_start} !== {e.seg, e.dp, e.an, e.fs}) begin
                miscompares++;
                $display("FAIL scan t=%0t: got seg=%h dp=%b an=%b fs=%b, expected seg=%h dp=%b an=%b fs=%b",
                         $time, seg, dp, an, frame_start, e.seg, e.dp, e.an, e.fs);
            end
        end
    end

    task automatic run(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Stimulus: directed scenarios followed by randomized traffic.
    initial begin
        rst = 1'b0; number = 16'h0000; dp_in = 4'h0; blank_lz = 1'b0;
        brightness = 2'd3; enable = 1'b1;
        run(3);
        if ({seg, dp, an, frame_start} !== {7'h7F, 1'b1, 4'hF, 1'b0}) begin
            miscompares++;
            $display("FAIL reset t=%0t: got seg=%h dp=%b an=%b fs=%b, expected seg=7f dp=1 an=1111 fs=0",
                     $time, seg, dp, an, frame_start);
        end
        number = 16'h1234; rst = 1'b1;
        fs_seen = 1'b0;
        run(1);
        if (frame_start === 1'b1) fs_seen = 1'b1;
        run(1);
        if (frame_start === 1'b1) fs_seen = 1'b1;
        if (!fs_seen) begin
            miscompares++;
            $display("FAIL timeout t=%0t: no frame_start pulse within 2 clks of reset release", $time);
        end
        run(38);
        number = 16'hABCD;
        run(37);
        number = 16'h0050; blank_lz = 1'b1;
        run(20);
        number = 16'h0000;
        run(20);
        blank_lz = 1'b0;
        run(20);
        brightness = 2'd0;
        run(20);
        brightness = 2'd1;
        run(20);
        brightness = 2'd3; enable = 1'b0;
        run(20);
        enable = 1'b1; number = 16'h9E7F; dp_in = 4'b0100;
        run(27);
        rst = 1'b0;
        run(2);
        rst = 1'b1;
        run(24);
        for (int k = 0; k < 800; k++) begin
            if ($urandom_range(0, 7) == 0)  number     = 16'($urandom);
            if ($urandom_range(0, 15) == 0) dp_in      = 4'($urandom);
            if ($urandom_range(0, 15) == 0) blank_lz   = 1'($urandom);
            if ($urandom_range(0, 11) == 0) brightness = 2'($urandom);
            enable = ($urandom_range(0, 9) != 0);
            rst    = ($urandom_range(0, 79) != 0);
            run(1);
        end
        run(1);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        if (miscompares == 0) $display("PASS");
        else                  $display("FAIL");
        $finish;
    end

endmodule
`default_nettype wire
